degamma_stream: RTL and testbench

- Streaming inverse-gamma (linearisation) block. It is the decode side of the fixed display-gamma encoder already in the video path.
- Maps each 8-bit R/G/B component through a host-programmable 256-entry table, with AXI-Stream-style valid/ready on both sides.
- Sits between the HDMI-in video stream and the enhancement pipeline, so downstream processing runs on linear-light values.
- After reset the table self-initialises to identity. Software then loads the inverse curve.

---
 rtl/degamma_pkg.sv | 23 ++
 rtl/degamma_lut_ram.sv | 32 +++
 rtl/degamma_stream.sv | 168 ++++++++++++++++
 tb/tb_degamma_stream.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/degamma_pkg.sv
// degamma_pkg: shared constants, FSM state type and slice helper for the
// degamma_stream inverse-gamma lookup block.
//   DEF_DATA_W   default bits per colour component
//   DEF_CHANNELS default components per pixel (R,G,B packed MSB-first)
//   LUT_DEPTH    table entries per channel at the default width
package degamma_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_CHANNELS = 3;
  localparam int LUT_DEPTH    = 2 ** DEF_DATA_W;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // LSB position of component `ch` in a packed pixel; channel 0 (R) is the
  // most significant component.
  function automatic int comp_lo(input int ch, input int n_ch, input int w);
    return (n_ch - 1 - ch) * w;
  endfunction

endpackage

// File: rtl/degamma_lut_ram.sv
// degamma_lut_ram: one channel table, 2**DATA_W x DATA_W.
//   clk        system clock
//   wr_en_i    write strobe; wr_addr_i / wr_data_i select entry and value
//   rd_en_i    read enable; rd_addr_i is captured into rd_data_o on the edge
//   rd_data_o  registered read data (read-first against a same-edge write)
module degamma_lut_ram #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**DATA_W];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the table and its read register carry no reset so this maps onto
  // block RAM; the owner's INIT sweep gives the contents a defined state.
  // Non-blocking assignments make the read see the pre-write value when
  // both ports hit the same entry on one edge.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/degamma_stream.sv
// degamma_stream: streaming inverse-gamma lookup, one table per component.
//   clk, rst                 system clock, synchronous active-high reset
//   s_tdata/tvalid/tready    input pixel stream (s_tuser = SOF, s_tlast = EOL)
//   m_tdata/tvalid/tready    linearised pixel stream, flags travel with data
//   lut_wr_en/addr/data      host table write, same value to every channel
//   lut_ready                table initialised, host writes accepted
// Build option DEGAMMA_DBL_BUF_EN: double-banked tables. Host writes go to
// the shadow bank; lut_commit arms a swap that executes on the next accepted
// SOF beat (which already reads the new bank); lut_pending shows an armed swap.
module degamma_stream
  import degamma_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W*CHANNELS-1:0] s_tdata,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic                       s_tuser,
  input  logic                       s_tlast,
  output logic [DATA_W*CHANNELS-1:0] m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tuser,
  output logic                       m_tlast,
  input  logic                       lut_wr_en,
  input  logic [DATA_W-1:0]          lut_wr_addr,
  input  logic [DATA_W-1:0]          lut_wr_data,
  output logic                       lut_ready
`ifdef DEGAMMA_DBL_BUF_EN
  ,
  input  logic                       lut_commit,
  output logic                       lut_pending
`endif
);

  localparam int PIX_W = DATA_W * CHANNELS;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;

  logic              advance, accept, in_init, host_wr;
  logic [DATA_W-1:0] ram_wr_addr, ram_wr_data;
  logic [PIX_W-1:0]  s1_data;

  logic              v1_q, user1_q, last1_q;
  logic              m_tvalid_q, m_tuser_q, m_tlast_q;
  logic [PIX_W-1:0]  m_tdata_q;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = RUN;
      end
      RUN: state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign in_init     = (state_q == INIT);
  assign host_wr     = (state_q == RUN) && lut_wr_en;
  assign ram_wr_addr = in_init ? cnt_q : lut_wr_addr;
  assign ram_wr_data = in_init ? cnt_q : lut_wr_data;
  assign lut_ready   = (state_q == RUN);

  // Output register empty or draining: the whole pipe may step.
  assign advance  = !m_tvalid_q || m_tready;
  assign s_tready = (state_q == RUN) && advance;
  assign accept   = s_tvalid && s_tready;

  // ---------------- tables ----------------
`ifdef DEGAMMA_DBL_BUF_EN
  logic active_q, sel1_q, pending_q, swap_now;

  // The swapping SOF beat must already read the new bank, so the bank
  // choice is made per beat and carried alongside it into stage 1.
  assign swap_now    = accept && s_tuser && (pending_q || lut_commit);
  assign lut_pending = pending_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= 1'b0;
      pending_q <= 1'b0;
      sel1_q    <= 1'b0;
    end else begin
      active_q  <= active_q ^ swap_now;
      pending_q <= swap_now ? 1'b0 : (pending_q || lut_commit);
      if (advance) sel1_q <= active_q ^ swap_now;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [DATA_W-1:0] rd_data [2];
    for (genvar b = 0; b < 2; b++) begin : g_bank
      degamma_lut_ram #(.DATA_W(DATA_W)) u_ram (
        .clk       (clk),
        .wr_en_i   (in_init || (host_wr && (active_q != 1'(b)))),
        .wr_addr_i (ram_wr_addr),
        .wr_data_i (ram_wr_data),
        .rd_en_i   (advance),
        .rd_addr_i (s_tdata[comp_lo(ch, CHANNELS, DATA_W) +: DATA_W]),
        .rd_data_o (rd_data[b])
      );
    end
    assign s1_data[comp_lo(ch, CHANNELS, DATA_W) +: DATA_W] =
      sel1_q ? rd_data[1] : rd_data[0];
  end
`else
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    degamma_lut_ram #(.DATA_W(DATA_W)) u_ram (
      .clk       (clk),
      .wr_en_i   (in_init || host_wr),
      .wr_addr_i (ram_wr_addr),
      .wr_data_i (ram_wr_data),
      .rd_en_i   (advance),
      .rd_addr_i (s_tdata[comp_lo(ch, CHANNELS, DATA_W) +: DATA_W]),
      .rd_data_o (s1_data[comp_lo(ch, CHANNELS, DATA_W) +: DATA_W])
    );
  end
`endif

  // ---------------- pipeline ----------------
  // Stage 1 data lives in the table read registers; only its valid and
  // sideband flags are held here. Stage 2 is the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      user1_q    <= 1'b0;
      last1_q    <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tuser_q  <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else if (advance) begin
      v1_q       <= accept;
      user1_q    <= s_tuser;
      last1_q    <= s_tlast;
      m_tvalid_q <= v1_q;
      m_tdata_q  <= s1_data;
      m_tuser_q  <= user1_q;
      m_tlast_q  <= last1_q;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tuser  = m_tuser_q;
  assign m_tlast  = m_tlast_q;

endmodule

// File: tb/tb_degamma_stream.sv
// tb_degamma_stream: directed vectors for degamma_stream. Inputs change on
// the falling edge; outputs are sampled on the falling edge or 4 time units
// into the low phase, both clear of the rising edge.
module tb_degamma_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] s_tdata;
  logic        s_tvalid, s_tready, s_tuser, s_tlast;
  logic [23:0] m_tdata;
  logic        m_tvalid, m_tready, m_tuser, m_tlast;
  logic        lut_wr_en;
  logic [7:0]  lut_wr_addr, lut_wr_data;
  logic        lut_ready;
`ifdef DEGAMMA_DBL_BUF_EN
  logic        lut_commit, lut_pending;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  degamma_stream dut (
    .clk         (clk),
    .rst         (rst),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tuser     (s_tuser),
    .s_tlast     (s_tlast),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tuser     (m_tuser),
    .m_tlast     (m_tlast),
    .lut_wr_en   (lut_wr_en),
    .lut_wr_addr (lut_wr_addr),
    .lut_wr_data (lut_wr_data),
    .lut_ready   (lut_ready)
`ifdef DEGAMMA_DBL_BUF_EN
    ,
    .lut_commit  (lut_commit),
    .lut_pending (lut_pending)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic lut_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    lut_wr_en = 1'b1; lut_wr_addr = a; lut_wr_data = d;
    @(negedge clk);
    lut_wr_en = 1'b0;
  endtask

  // Counts falling edges, starting with the current one, on which s_tready is low.
  task automatic wait_init(output int n);
    n = 0;
    while (!s_tready && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Offers one beat (optionally with a table write in its first cycle) and
  // returns the output beat. aw = cycles spent waiting for acceptance.
  task automatic xfer(input logic [23:0] d, input logic u, input logic l,
                      input logic we, input logic [7:0] wa, input logic [7:0] wd,
                      output logic [23:0] od, output logic ou, output logic ol,
                      output int aw);
    int  n;
    bit  acc;
    @(negedge clk);
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    lut_wr_en = we; lut_wr_addr = wa; lut_wr_data = wd;
    n = 0; acc = 1'b0;
    while (!acc && n < 50) begin
      #4;
      acc = s_tready;
      @(negedge clk);
      lut_wr_en = 1'b0;
      n++;
    end
    s_tvalid = 1'b0;
    aw = n - 1;
    check("accept", 32'(acc), 32'd1);
    n = 0;
    while (!m_tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("output valid", 32'(m_tvalid), 32'd1);
    od = m_tdata; ou = m_tuser; ol = m_tlast;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] od;
    logic        ou, ol;
    int          aw, n;

    rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1; lut_wr_en = 1'b0; lut_wr_addr = '0; lut_wr_data = '0;
`ifdef DEGAMMA_DBL_BUF_EN
    lut_commit = 1'b0;
`endif

    // ---- 1: reset state, INIT length, identity pass-through ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst m_tdata", 32'(m_tdata), 32'd0);
    check("rst m_tuser", 32'(m_tuser), 32'd0);
    check("rst m_tlast", 32'(m_tlast), 32'd0);
    check("rst s_tready", 32'(s_tready), 32'd0);
    check("rst lut_ready", 32'(lut_ready), 32'd0);
    rst = 1'b0;
    s_tvalid = 1'b1; s_tdata = 24'h123456;
    wait_init(n);
    check("t1 init cycles", 32'(n), 32'd256);
    check("t1 lut_ready", 32'(lut_ready), 32'd1);
    @(negedge clk);
    s_tvalid = 1'b0;
    check("t1 lat1 m_tvalid", 32'(m_tvalid), 32'd0);
    @(negedge clk);
    check("t1 lat2 m_tvalid", 32'(m_tvalid), 32'd1);
    check("t1 identity", 32'(m_tdata), 32'h123456);
    @(negedge clk);
    check("t1 bubble", 32'(m_tvalid), 32'd0);

    // ---- 2: programmed entries, flags preserved ----
    lut_write(8'd74, 8'd128);
    lut_write(8'd21, 8'd64);
    lut_write(8'd255, 8'd255);
    xfer(24'h4A15FF, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, od, ou, ol, aw);
    check("t2 data", 32'(od), 32'h8040FF);
    check("t2 tuser", 32'(ou), 32'd1);
    check("t2 tlast", 32'(ol), 32'd1);
    xfer(24'h00FF4A, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, od, ou, ol, aw);
    check("t2b data", 32'(od), 32'h00FF80);
    check("t2b tuser", 32'(ou), 32'd0);
    check("t2b tlast", 32'(ol), 32'd1);

    // ---- 3: burst with a 5-cycle downstream stall ----
    begin
      int          c, idx, rcv;
      bit          holding;
      logic [23:0] held;
      c = 0; idx = 0; rcv = 0; holding = 1'b0; held = '0;
      while (rcv < 10 && c < 60) begin
        @(negedge clk);
        m_tready = !(c >= 3 && c < 8);
        if (idx < 10) begin
          s_tvalid = 1'b1;
          s_tdata  = 24'((idx + 1) * 24'h010101);
          s_tuser  = (idx == 0);
          s_tlast  = (idx == 9);
        end else begin
          s_tvalid = 1'b0;
        end
        #4;
        if (m_tvalid && !m_tready) begin
          if (holding) check("t3 stable", 32'(m_tdata), 32'(held));
          check("t3 s_tready stall", 32'(s_tready), 32'd0);
          held = m_tdata;
          holding = 1'b1;
        end else begin
          holding = 1'b0;
        end
        if (m_tvalid && m_tready) begin
          check("t3 beat", 32'(m_tdata), 32'((rcv + 1) * 24'h010101));
          rcv++;
        end
        if (s_tvalid && s_tready) idx++;
        c++;
      end
      check("t3 beats out", 32'(rcv), 32'd10);
      @(negedge clk);
      s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    end

    // ---- 4: read-first on a same-cycle write ----
    xfer(24'h070707, 1'b0, 1'b0, 1'b1, 8'd7, 8'd200, od, ou, ol, aw);
    check("t4 same-cycle accept", 32'(aw), 32'd0);
    check("t4 old value", 32'(od), 32'h070707);
    xfer(24'h070707, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, od, ou, ol, aw);
    check("t4 new value", 32'(od), 32'hC8C8C8);

    // ---- 5: reset with two beats in flight ----
    @(negedge clk);
    s_tvalid = 1'b1; s_tdata = 24'h4A4A4A;
    @(negedge clk);
    s_tdata = 24'h151515;
    @(negedge clk);
    check("t5 in flight", 32'(m_tvalid), 32'd1);
    s_tvalid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("t5 m_tvalid", 32'(m_tvalid), 32'd0);
    check("t5 s_tready", 32'(s_tready), 32'd0);
    check("t5 lut_ready", 32'(lut_ready), 32'd0);
    rst = 1'b0;
    wait_init(n);
    check("t5 init cycles", 32'(n), 32'd256);
    @(negedge clk);
    check("t5 drained", 32'(m_tvalid), 32'd0);
    xfer(24'h4A0715, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, od, ou, ol, aw);
    check("t5 identity", 32'(od), 32'h4A0715);

`ifdef DEGAMMA_DBL_BUF_EN
    // ---- 6: shadow bank, swap on next SOF ----
    lut_write(8'd10, 8'd99);
    @(negedge clk);
    lut_commit = 1'b1;
    @(negedge clk);
    lut_commit = 1'b0;
    xfer(24'h0A0A0A, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, od, ou, ol, aw);
    check("t6 pre-swap", 32'(od), 32'h0A0A0A);
    check("t6 pending", 32'(lut_pending), 32'd1);
    xfer(24'h0A0A0A, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, od, ou, ol, aw);
    check("t6 swapped", 32'(od), 32'h636363);
    check("t6 pending clr", 32'(lut_pending), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
